// File: rtl/cache_tag_nway_if.sv
// Request/response and AXI-bridge handshake bundle for the cache tag unit.
// The slave side is the tag unit; the master side is the pipeline plus bridge.
interface cache_tag_nway_if #(
    parameter int ADDR_W = 32,
    parameter int WAYS   = 4
);
    localparam int WSEL_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic              flush;
    logic              req_valid;
    logic              req_wen;
    logic              req_cached;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              hit;
    logic [WAYS-1:0]   hit_way;
    logic [WSEL_W-1:0] way_sel;
    logic              stallreq;
    logic              wb_req;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_done;
    logic              rf_req;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_done;

    modport master (
        output flush, req_valid, req_wen, req_cached, req_addr, wb_done, rf_done,
        input  req_ready, resp_valid, hit, hit_way, way_sel, stallreq,
               wb_req, wb_addr, rf_req, rf_addr
    );

    modport slave (
        input  flush, req_valid, req_wen, req_cached, req_addr, wb_done, rf_done,
        output req_ready, resp_valid, hit, hit_way, way_sel, stallreq,
               wb_req, wb_addr, rf_req, rf_addr
    );
endinterface

// File: rtl/cache_tag_nway.sv
// N-way set-associative tag/control unit: tag compare, valid/dirty tracking,
// tree pseudo-LRU replacement and a write-back/refill miss sequencer.
module cache_tag_nway #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5,
    parameter int INDEX_W  = 7,
    parameter int WAYS     = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_tag_nway_if.slave bus
);
    localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS   = 1 << INDEX_W;
    localparam int WSEL_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [2:0] {S_RUN, S_WB, S_RF, S_UNC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                vld_p1_q, vld_p1_d;
    logic                flush_q, flush_d;
    logic [ADDR_W-1:0]   addr_p1_q;
    logic                wen_p1_q;
    logic                cached_p1_q;
    logic [WSEL_W-1:0]   victim_q;
    logic [TAG_W-1:0]    tag_mem_q [WAYS][SETS];
    logic [TAG_W-1:0]    tag_rd_q  [WAYS];
    logic [WAYS-1:0]     valid_q   [SETS];
    logic [WAYS-1:0]     dirty_q   [SETS];
    logic [PLRU_W-1:0]   plru_q    [SETS];

    logic [INDEX_W-1:0]  idx_req, idx_p1;
    logic [TAG_W-1:0]    tag_p1;
    logic [WAYS-1:0]     hit_vec;
    logic [WSEL_W-1:0]   hit_idx, victim_c;
    logic                live_p1, hit_p1, miss_p1, unc_p1;
    logic                ready_c, accept, fill, resp_done;

    // Walk the tree from the root: a node bit of 0 sends the victim to the lower half.
    function automatic logic [WSEL_W-1:0] plru_victim(input logic [PLRU_W-1:0] bits);
        logic [WSEL_W-1:0] w;
        logic [PLRU_W-1:0] sh;
        int n;
        w = '0;
        n = 0;
        if (WAYS > 1) begin
            for (int l = 0; l < WSEL_W; l++) begin
                sh = bits >> n;
                w  = (w << 1) | WSEL_W'(sh[0]);
                n  = 2 * n + (sh[0] ? 2 : 1);
            end
        end
        return w;
    endfunction

    // Point every node on way w's path away from w.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WSEL_W-1:0] w);
        logic [PLRU_W-1:0] r, mask;
        logic [WSEL_W-1:0] sw;
        int n;
        r = bits;
        n = 0;
        if (WAYS > 1) begin
            for (int l = 0; l < WSEL_W; l++) begin
                sw   = w >> (WSEL_W - 1 - l);
                mask = PLRU_W'(1) << n;
                r    = sw[0] ? (r & ~mask) : (r | mask);
                n    = 2 * n + (sw[0] ? 2 : 1);
            end
        end
        return r;
    endfunction

    assign idx_req = bus.req_addr[OFFSET_W +: INDEX_W];
    assign idx_p1  = addr_p1_q[OFFSET_W +: INDEX_W];
    assign tag_p1  = addr_p1_q[ADDR_W-1 -: TAG_W];

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx_p1][w] && tag_rd_q[w] == tag_p1) begin
                hit_vec[w] = 1'b1;
                hit_idx    = WSEL_W'(w);
            end
        end
    end

    always_comb begin
        victim_c = plru_victim(plru_q[idx_p1]);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx_p1][w]) victim_c = WSEL_W'(w);
        end
    end

    assign live_p1 = vld_p1_q && !bus.flush && state_q == S_RUN;
    assign hit_p1  = live_p1 && cached_p1_q && (|hit_vec);
    assign miss_p1 = live_p1 && cached_p1_q && !(|hit_vec);
    assign unc_p1  = live_p1 && !cached_p1_q;
    assign ready_c = state_q == S_RUN && !miss_p1 && !unc_p1;
    assign accept  = bus.req_valid && ready_c;
    assign fill    = state_q == S_RF && bus.rf_done;

    // Stage 0 -> stage 1: capture the request and read every way's tag.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p1_q   <= bus.req_addr;
            wen_p1_q    <= bus.req_wen;
            cached_p1_q <= bus.req_cached;
            for (int w = 0; w < WAYS; w++) tag_rd_q[w] <= tag_mem_q[w][idx_req];
        end
        if (miss_p1) victim_q <= victim_c;
        if (fill) tag_mem_q[victim_q][idx_p1] <= tag_p1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else if (hit_p1) begin
            plru_q[idx_p1] <= plru_touch(plru_q[idx_p1], hit_idx);
            if (wen_p1_q) dirty_q[idx_p1][hit_idx] <= 1'b1;
        end else if (fill) begin
            valid_q[idx_p1][victim_q] <= 1'b1;
            dirty_q[idx_p1][victim_q] <= wen_p1_q;
            plru_q[idx_p1]            <= plru_touch(plru_q[idx_p1], victim_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            vld_p1_q <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            vld_p1_q <= vld_p1_d;
            flush_q  <= flush_d;
        end
    end

    // A missing request stays parked in stage 1 until DONE retires it.
    always_comb begin
        state_d  = state_q;
        vld_p1_d = vld_p1_q;
        flush_d  = flush_q;
        case (state_q)
            S_RUN: begin
                vld_p1_d = accept || miss_p1 || unc_p1;
                if (miss_p1)
                    state_d = (valid_q[idx_p1][victim_c] && dirty_q[idx_p1][victim_c]) ? S_WB : S_RF;
                else if (unc_p1)
                    state_d = S_UNC;
            end
            S_WB: begin
                if (bus.wb_done) state_d = S_RF;
                if (bus.flush) flush_d = 1'b1;
            end
            S_RF, S_UNC: begin
                if (bus.rf_done) state_d = S_DONE;
                if (bus.flush) flush_d = 1'b1;
            end
            S_DONE: begin
                state_d  = S_RUN;
                vld_p1_d = 1'b0;
                flush_d  = 1'b0;
            end
            default: state_d = S_RUN;
        endcase
    end

    assign resp_done = state_q == S_DONE && !flush_q;

    always_comb begin
        bus.req_ready  = ready_c;
        bus.resp_valid = hit_p1 || resp_done;
        bus.hit        = hit_p1 || (resp_done && cached_p1_q);
        bus.hit_way    = '0;
        if (hit_p1) begin
            bus.hit_way = hit_vec;
        end else if (resp_done && cached_p1_q) begin
            for (int w = 0; w < WAYS; w++) bus.hit_way[w] = (victim_q == WSEL_W'(w));
        end
        bus.way_sel  = (state_q == S_RUN) ? hit_idx : victim_q;
        bus.stallreq = miss_p1 || unc_p1 || state_q == S_WB || state_q == S_RF || state_q == S_UNC;
        bus.wb_req   = state_q == S_WB;
        bus.wb_addr  = {tag_rd_q[victim_q], idx_p1, {OFFSET_W{1'b0}}};
        bus.rf_req   = state_q == S_RF || state_q == S_UNC;
        bus.rf_addr  = (state_q == S_UNC) ? addr_p1_q
                                          : {addr_p1_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end
endmodule

// File: tb/tb_cache_tag_nway.sv
// Directed bench for cache_tag_nway (4 ways, 128 sets, 32 B lines).
module tb_cache_tag_nway;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;

    cache_tag_nway_if #(.ADDR_W(32), .WAYS(4)) bus ();

    cache_tag_nway #(.ADDR_W(32), .OFFSET_W(5), .INDEX_W(7), .WAYS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic        o_resp, o_hit, o_stall1, o_ready1;
    logic [3:0]  o_hitway;
    logic [1:0]  o_wbsel;
    logic [31:0] o_wb_addr, o_rf_addr;
    int          o_wb_first, o_rf_first, o_resp_cyc, o_wait;

    // Issue one request and play the bridge: each done pulse comes on the
    // second cycle its request is high. fmode 1 flushes stage 1, 2 flushes the first RF cycle.
    task automatic xact(input logic [31:0] a, input logic w, input logic c, input int fmode);
        int  cyc;
        bit  done;
        o_resp = 0; o_hit = 0; o_hitway = '0; o_wbsel = '0; o_stall1 = 0; o_ready1 = 0;
        o_wb_addr = '0; o_rf_addr = '0;
        o_wb_first = -1; o_rf_first = -1; o_resp_cyc = -1; o_wait = 0;
        bus.req_valid = 1; bus.req_wen = w; bus.req_cached = c; bus.req_addr = a;
        #1;
        while (!bus.req_ready && o_wait < 50) begin
            @(posedge clk); #1;
            o_wait++;
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
        cyc = 1; done = 0;
        while (!done && cyc < 40) begin
            if (bus.wb_req && o_wb_first < 0) begin
                o_wb_first = cyc; o_wb_addr = bus.wb_addr; o_wbsel = bus.way_sel;
            end
            if (bus.rf_req && o_rf_first < 0) begin
                o_rf_first = cyc; o_rf_addr = bus.rf_addr;
            end
            bus.wb_done = bus.wb_req && (cyc == o_wb_first + 1);
            bus.rf_done = bus.rf_req && (cyc == o_rf_first + 1);
            bus.flush   = (fmode == 1 && cyc == 1) || (fmode == 2 && cyc == o_rf_first);
            #1;
            if (cyc == 1) begin o_stall1 = bus.stallreq; o_ready1 = bus.req_ready; end
            if (bus.resp_valid) begin
                o_resp = 1; o_hit = bus.hit; o_hitway = bus.hit_way; o_resp_cyc = cyc; done = 1;
            end else if (bus.req_ready) begin
                done = 1;
            end
            @(posedge clk); #1;
            bus.wb_done = 0; bus.rf_done = 0; bus.flush = 0;
            cyc++;
        end
        nvec++;
        if (!done || o_wait >= 50) begin
            nerr++;
            $display("FAIL xact_timeout addr=%h wait=%0d cycles=%0d", a, o_wait, cyc);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = 0; bus.req_wen = 0; bus.req_cached = 0; bus.req_addr = '0;
        bus.flush = 0; bus.wb_done = 0; bus.rf_done = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL rst_resp got=%b exp=0", bus.resp_valid); end
        nvec++; if (bus.hit !== 1'b0) begin nerr++; $display("FAIL rst_hit got=%b exp=0", bus.hit); end
        nvec++; if (bus.hit_way !== 4'b0000) begin nerr++; $display("FAIL rst_hit_way got=%b exp=0000", bus.hit_way); end
        nvec++; if (bus.wb_req !== 1'b0) begin nerr++; $display("FAIL rst_wb_req got=%b exp=0", bus.wb_req); end
        nvec++; if (bus.rf_req !== 1'b0) begin nerr++; $display("FAIL rst_rf_req got=%b exp=0", bus.rf_req); end
        nvec++; if (bus.stallreq !== 1'b0) begin nerr++; $display("FAIL rst_stall got=%b exp=0", bus.stallreq); end
        nvec++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
        // Stray completion pulses while idle must do nothing.
        bus.wb_done = 1; bus.rf_done = 1;
        @(posedge clk); #1;
        bus.wb_done = 0; bus.rf_done = 0;
        #1;
        nvec++; if ({bus.resp_valid, bus.wb_req, bus.rf_req, bus.req_ready} !== 4'b0001) begin
            nerr++; $display("FAIL stray_done got=%b exp=0001", {bus.resp_valid, bus.wb_req, bus.rf_req, bus.req_ready});
        end
    endtask

    task automatic test_clean_miss();
        do_reset();
        xact(32'h0000_1000, 0, 1, 0);
        nvec++; if (o_stall1 !== 1'b1) begin nerr++; $display("FAIL miss_stall got=%b exp=1", o_stall1); end
        nvec++; if (o_ready1 !== 1'b0) begin nerr++; $display("FAIL miss_ready got=%b exp=0", o_ready1); end
        nvec++; if (o_wb_first !== -1) begin nerr++; $display("FAIL miss_no_wb got=%0d exp=-1", o_wb_first); end
        nvec++; if (o_rf_first !== 2) begin nerr++; $display("FAIL miss_rf_cyc got=%0d exp=2", o_rf_first); end
        nvec++; if (o_rf_addr !== 32'h0000_1000) begin nerr++; $display("FAIL miss_rf_addr got=%h exp=00001000", o_rf_addr); end
        nvec++; if (o_resp_cyc !== 4) begin nerr++; $display("FAIL miss_resp_cyc got=%0d exp=4", o_resp_cyc); end
        nvec++; if ({o_hit, o_hitway} !== 5'b1_0001) begin nerr++; $display("FAIL miss_hit got=%b exp=10001", {o_hit, o_hitway}); end
        xact(32'h0000_1000, 0, 1, 0);
        nvec++; if (o_wait !== 0) begin nerr++; $display("FAIL next_accept got=%0d exp=0", o_wait); end
        nvec++; if (o_resp_cyc !== 1) begin nerr++; $display("FAIL rehit_cyc got=%0d exp=1", o_resp_cyc); end
        nvec++; if ({o_hit, o_hitway, o_stall1} !== 6'b1_0001_0) begin
            nerr++; $display("FAIL rehit got=%b exp=100010", {o_hit, o_hitway, o_stall1});
        end
    endtask

    task automatic test_plru_fill();
        logic [31:0] addrs [5] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
        logic [3:0]  ways  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            xact(addrs[i], 0, 1, 0);
            nvec++; if (o_hitway !== ways[i] || o_resp_cyc !== 4) begin
                nerr++; $display("FAIL fill_%0d way got=%b/%0d exp=%b/4", i, o_hitway, o_resp_cyc, ways[i]);
            end
            nvec++; if (o_wb_first !== -1) begin nerr++; $display("FAIL fill_%0d_wb got=%0d exp=-1", i, o_wb_first); end
        end
    endtask

    task automatic test_dirty_wb();
        logic [31:0] addrs [3] = '{32'h0000_5000, 32'h0000_6000, 32'h0000_7000};
        logic [3:0]  ways  [3] = '{4'b0100, 4'b0001, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) xact(32'(i) << 12, 0, 1, 0);
        xact(32'h0000_1000, 1, 1, 0);
        nvec++; if (o_resp_cyc !== 1 || o_hitway !== 4'b0010) begin
            nerr++; $display("FAIL store_hit got=%0d/%b exp=1/0010", o_resp_cyc, o_hitway);
        end
        for (int i = 0; i < 3; i++) begin
            xact(addrs[i], 0, 1, 0);
            nvec++; if (o_hitway !== ways[i] || o_wb_first !== -1) begin
                nerr++; $display("FAIL evict_%0d got=%b/%0d exp=%b/-1", i, o_hitway, o_wb_first, ways[i]);
            end
        end
        xact(32'h0000_8000, 0, 1, 0);
        nvec++; if (o_wb_first !== 2) begin nerr++; $display("FAIL wb_cyc got=%0d exp=2", o_wb_first); end
        nvec++; if (o_wb_addr !== 32'h0000_1000) begin nerr++; $display("FAIL wb_addr got=%h exp=00001000", o_wb_addr); end
        nvec++; if (o_wbsel !== 2'd1) begin nerr++; $display("FAIL wb_way_sel got=%0d exp=1", o_wbsel); end
        nvec++; if (o_rf_first !== 4) begin nerr++; $display("FAIL wb_rf_cyc got=%0d exp=4", o_rf_first); end
        nvec++; if (o_resp_cyc !== 6 || o_hitway !== 4'b0010) begin
            nerr++; $display("FAIL wb_resp got=%0d/%b exp=6/0010", o_resp_cyc, o_hitway);
        end
    endtask

    task automatic test_uncached();
        do_reset();
        xact(32'hBFAF_8004, 0, 0, 0);
        nvec++; if (o_rf_first !== 2 || o_rf_addr !== 32'hBFAF_8004) begin
            nerr++; $display("FAIL unc_rf got=%0d/%h exp=2/bfaf8004", o_rf_first, o_rf_addr);
        end
        nvec++; if (o_stall1 !== 1'b1) begin nerr++; $display("FAIL unc_stall got=%b exp=1", o_stall1); end
        nvec++; if ({o_resp, o_hit, o_hitway} !== 6'b10_0000 || o_resp_cyc !== 4) begin
            nerr++; $display("FAIL unc_resp got=%b/%0d exp=100000/4", {o_resp, o_hit, o_hitway}, o_resp_cyc);
        end
        xact(32'hBFAF_8008, 0, 1, 0);
        nvec++; if (o_rf_first !== 2 || o_rf_addr !== 32'hBFAF_8000) begin
            nerr++; $display("FAIL unc_then_cached got=%0d/%h exp=2/bfaf8000", o_rf_first, o_rf_addr);
        end
        nvec++; if ({o_hit, o_hitway} !== 5'b1_0001) begin nerr++; $display("FAIL unc_then_cached_hit got=%b exp=10001", {o_hit, o_hitway}); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) xact(32'(i) << 12, 0, 1, 0);
        xact(32'h0000_0000, 0, 1, 1);
        nvec++; if (o_resp !== 1'b0 || o_stall1 !== 1'b0) begin
            nerr++; $display("FAIL flush_hit got=resp%b stall%b exp=resp0 stall0", o_resp, o_stall1);
        end
        xact(32'h0000_4000, 0, 1, 0);
        nvec++; if (o_hitway !== 4'b0001) begin nerr++; $display("FAIL flush_plru got=%b exp=0001", o_hitway); end
        xact(32'h0000_5000, 0, 1, 2);
        nvec++; if (o_resp !== 1'b0 || o_rf_first !== 2) begin
            nerr++; $display("FAIL flush_rf got=resp%b rf%0d exp=resp0 rf2", o_resp, o_rf_first);
        end
        xact(32'h0000_5000, 0, 1, 0);
        nvec++; if (o_resp_cyc !== 1 || o_hitway !== 4'b0100) begin
            nerr++; $display("FAIL flush_rf_installed got=%0d/%b exp=1/0100", o_resp_cyc, o_hitway);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        xact(32'h0000_1000, 0, 1, 0);
        xact(32'h0000_2000, 0, 1, 0);
        bus.req_valid = 1; bus.req_wen = 0; bus.req_cached = 1; bus.req_addr = 32'h0000_1000;
        @(posedge clk); #1;
        bus.req_addr = 32'h0000_2000;
        #1;
        nvec++; if ({bus.resp_valid, bus.hit_way, bus.req_ready} !== 6'b1_0001_1) begin
            nerr++; $display("FAIL b2b_0 got=%b exp=100011", {bus.resp_valid, bus.hit_way, bus.req_ready});
        end
        @(posedge clk); #1;
        bus.req_addr = 32'h0000_1000;
        #1;
        nvec++; if ({bus.resp_valid, bus.hit_way, bus.req_ready} !== 6'b1_0010_1) begin
            nerr++; $display("FAIL b2b_1 got=%b exp=100101", {bus.resp_valid, bus.hit_way, bus.req_ready});
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
        #1;
        nvec++; if ({bus.resp_valid, bus.hit_way} !== 5'b1_0001) begin
            nerr++; $display("FAIL b2b_2 got=%b exp=10001", {bus.resp_valid, bus.hit_way});
        end
        @(posedge clk); #1;
        nvec++; if (bus.resp_valid !== 1'b0) begin nerr++; $display("FAIL b2b_idle got=%b exp=0", bus.resp_valid); end
    endtask

    task automatic test_rst_mid_wb();
        do_reset();
        for (int i = 1; i < 5; i++) xact(32'(i) << 12, 1, 1, 0);
        bus.req_valid = 1; bus.req_wen = 0; bus.req_cached = 1; bus.req_addr = 32'h0000_5000;
        #1;
        @(posedge clk); #1;
        bus.req_valid = 0;
        @(posedge clk); #1;
        nvec++; if (bus.wb_req !== 1'b1 || bus.wb_addr !== 32'h0000_1000) begin
            nerr++; $display("FAIL pre_rst_wb got=%b/%h exp=1/00001000", bus.wb_req, bus.wb_addr);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        nvec++; if ({bus.wb_req, bus.rf_req, bus.stallreq, bus.req_ready} !== 4'b0001) begin
            nerr++; $display("FAIL rst_mid_wb got=%b exp=0001", {bus.wb_req, bus.rf_req, bus.stallreq, bus.req_ready});
        end
        xact(32'h0000_2000, 0, 1, 0);
        nvec++; if (o_rf_first !== 2 || o_wb_first !== -1 || o_resp_cyc !== 4) begin
            nerr++; $display("FAIL post_rst_miss got=rf%0d wb%0d resp%0d exp=rf2 wb-1 resp4", o_rf_first, o_wb_first, o_resp_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_plru_fill();
        test_dirty_wb();
        test_uncached();
        test_flush();
        test_back_to_back();
        test_rst_mid_wb();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_tag_nway.md
# cache_tag_nway

Parametrised N-way set-associative tag/control unit for the L1 caches. It sits between the pipeline's SRAM-style request port and the AXI bridge, and its hit/way outputs select the way in the data array. It tracks valid and dirty per line and uses a tree pseudo-LRU for replacement. A miss FSM sequences a dirty-victim write-back, then a refill; uncached requests pass through.

## Interface
- ADDR_W, 32, address width
- OFFSET_W, 5, line offset bits (32 B line)
- INDEX_W, 7, set index bits (128 sets)
- WAYS, 4, associativity; legal values 1, 2, 4, 8; TAG_W = ADDR_W-INDEX_W-OFFSET_W

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush  in  1  kill the in-flight request
- req_valid  in  1  request present
- req_wen  in  1  1 = store
- req_cached  in  1  1 = cacheable
- req_addr  in  ADDR_W  byte address
- req_ready  out  1  request accepted when req_valid & req_ready
- resp_valid  out  1  one-cycle pulse per completed request
- hit  out  1  with resp_valid: served from the cache
- hit_way  out  WAYS  one-hot way, valid with hit
- way_sel  out  max(1,log2 WAYS)  binary way for the data array; equals the hit way in RUN and the victim way in WB/RF/DONE
- stallreq  out  1  pipeline stall
- wb_req, wb_addr  out  1, ADDR_W  write-back request and line address {victim tag, index, 0}
- wb_done  in  1  write-back complete pulse
- rf_req, rf_addr  out  1, ADDR_W  refill/uncached read request; line-aligned if cached, exact address if uncached
- rf_done  in  1  read complete pulse

## Operation
- Storage:
  - Tags live in a synchronous-read array, written only on refill.
  - Valid, dirty and PLRU bits (WAYS-1 per set) live in flops. They reset to 0 and are read combinationally in stage 1.
- Pipeline:
  - Stage 0 registers the request and reads the tags.
  - Stage 1 compares {valid, tag} for all ways.
- FSM states: RUN, WB, RF, UNC, DONE.
- RUN, stage 1 valid and not flushed:
  - Cached hit: resp_valid=1, hit=1. PLRU is updated; if req_wen, the dirty bit of the hit way is set.
  - Cached miss: choose a victim. It is the lowest-numbered invalid way; if all ways are valid, the PLRU victim. Go to WB if the victim is valid and dirty, else go to RF.
  - Uncached: go to UNC. Tags, valid, dirty and PLRU are untouched.
- WB: wb_req held high until wb_done, then go to RF.
- RF: rf_req held high until rf_done. On that edge:
  - write {victim tag = request tag}
  - valid=1, dirty=req_wen
  - update PLRU toward the victim
  - go to DONE
- UNC: rf_req held high until rf_done, then go to DONE.
- DONE (one cycle):
  - resp_valid=1; hit=1 for a cached request, 0 for uncached.
  - Return to RUN.
- PLRU, per tree node:
  - A node bit of 0 means the victim is in the lower half.
  - An access to way w sets every node on w's path to point away from w.
  - WAYS=2 reduces to one bit; WAYS=1 has no PLRU and the victim is always way 0.
- flush:
  - In RUN it clears stage 1: no resp, no state update, no miss.
  - In WB/RF/UNC it is latched. The transaction completes and the line is still installed, but the DONE resp_valid is suppressed.
  - The latch clears when DONE is reached.
- req_ready = 1 only in RUN when stage 1 is empty or hitting. It is 0 in WB/RF/UNC/DONE and in the miss cycle.
- stallreq = stage-1 miss or uncached (not flushed) | state in {WB, RF, UNC}.

## Timing
- Reset state:
  - State RUN, stage 1 empty.
  - All valid/dirty/PLRU bits = 0.
  - resp_valid, hit, hit_way, wb_req, rf_req, stallreq = 0; req_ready = 1.
  - rst during WB/RF drops wb_req/rf_req on the next cycle.
- Hit: accepted at T, resp_valid at T+1; back-to-back hits sustain one per cycle.
- Clean miss:
  - Accepted at T, stallreq at T+1, rf_req from T+2.
  - rf_done at R gives resp_valid at R+1; the next accept is at R+2.
- Dirty miss:
  - wb_req from T+2 through the cycle of wb_done W.
  - rf_req from W+1.
- wb_done/rf_done outside their states are ignored.

## Test plan
(WAYS=4, INDEX_W=7, OFFSET_W=5)
- Reset, then load 0x0000_1000: miss, no wb_req, rf_addr=0x0000_1000. rf_done gives resp_valid&hit with hit_way=0001. Repeat the load: hit at T+1 with hit_way=0001.
- Loads 0x0000, 0x1000, 0x2000, 0x3000, then 0x4000 (all set 0): the first four fill ways 0-3. 0x4000 picks victim way 0 via PLRU, with no write-back.
- Store hit to 0x1000, then misses in set 0 until way 1 is the victim: wb_req with wb_addr=0x0000_1000 precedes rf_req.
- Uncached load 0xBFAF_8004: rf_addr=0xBFAF_8004, resp_valid with hit=0. A cached load to 0xBFAF_8000 afterwards still misses.
- flush with a stage-1 hit: no resp_valid and PLRU unchanged. flush during RF: no resp_valid, but a later access to that line hits.
- rst asserted mid-WB: wb_req low on the next cycle, req_ready=1, and the previously-hit lines now miss.
